cycle_seq: RTL
==============

Name: cycle_seq

Overview:
- Timing and sequencing controller for the 6502 core.
- Owns the instruction register and the 3-bit cycle counter that drive instdecode.
- Latches reset and NMI requests, qualifies IRQ, and injects the interrupt opcode (8'h00) at instruction boundaries.
- Advances the counter from the decoder's icyc/rcyc/scyc/sinst strobes, and flags a hang if the decoder stops sequencing.

Parameters:
INT_OP, 8'h00, opcode forced into inst when an interrupt or reset is taken.
HANG_LIMIT, 16, consecutive rdy-high cycles with no strobe before hang asserts (range 2..255).

Ports:
clk  in  1  system clock, all state updates on rising edge
clr  in  1  synchronous active-high reset
rdy  in  1  1 = advance; 0 = freeze sequencing (NMI edge capture continues)
din  in  8  data bus, opcode source on rcyc
irq  in  1  level interrupt request, active-high
nmi  in  1  non-maskable request, rising-edge sensitive
idis  in  1  status I flag; 1 masks irq
icyc  in  1  decoder: cycle <= cycle+1
rcyc  in  1  decoder: last cycle; cycle <= 0 and load next opcode
scyc  in  1  decoder: skip one cycle; cycle <= cycle+2
sinst  in  1  decoder: interrupt sequence accepted; retire highest pending source
inst  out  8  instruction register to decoder
cycle  out  3  cycle counter to decoder
rst_o  out  1  pending reset (decoder clr)
nmi_o  out  1  pending NMI (decoder nmi)
irq_o  out  1  qualified IRQ (decoder irq)
sync  out  1  1 during the first cycle of each instruction (cycle==0, registered)
hang  out  1  sticky; decoder failed to sequence

Behaviour:
- On clr=1 at a clock edge:
  - cycle=0, inst=INT_OP, rst_pend=1, nmi_pend=0, nmi_q=0, sync=1, hang=0, stall counter=0.
- clr overrides every other input, including mid-instruction.
- Outputs:
  - rst_o = rst_pend.
  - nmi_o = nmi_pend & ~rst_pend.
  - irq_o = irq & ~idis & ~rst_pend & ~nmi_pend. This is combinational; irq is never latched.
- NMI edge detect:
  - nmi_q <= nmi every clock, including when rdy=0.
  - nmi & ~nmi_q sets nmi_pend.
  - A new edge in the same cycle as an nmi_pend clear leaves nmi_pend=1 (set wins).
- sinst (rdy=1) clears the highest pending source: rst_pend if set, else nmi_pend. An IRQ has nothing to clear.
- Strobe priority when rdy=1: rcyc > scyc > icyc. With none asserted, cycle and inst hold.
  - rcyc: cycle<=0, sync<=1. inst<=INT_OP if (rst_pend | nmi_pend | irq_o) is true at that edge, else inst<=din.
  - scyc: cycle<=cycle+2 mod 8, so 6->0 and 7->1. sync<=0.
  - icyc: cycle<=cycle+1 mod 8, so 7->0. sync<=0. inst unchanged.
- rdy=0: cycle, inst, sync, pending clears and the stall counter all hold. NMI edge capture still sets nmi_pend.
- Hang detection:
  - The stall counter increments each rdy=1 cycle with no strobe and resets to 0 on any strobe.
  - Reaching HANG_LIMIT sets hang. The counter saturates at HANG_LIMIT.
  - hang clears only on clr.
- Latency: every registered output updates on the edge after the strobe; the decoder sees new cycle/inst the next cycle.
- Boundary case: nmi and irq both pending at rcyc → inst=INT_OP with nmi_o=1 and irq_o=0, so the decoder takes the NMI path.

Test Plan:
- Reset then boot: clr=1 for 1 clk, then icyc on cycles 0..6 and rcyc at cycle 7 with din=8'hA9. Required: cycle steps 0..7; rst_o=1 until sinst is pulsed at cycle 0; then inst=8'hA9, cycle=0, sync=1.
- IRQ masking: idis=1, irq=1, rcyc with din=8'hEA → inst=8'hEA, irq_o=0. Then idis=0 and rcyc again → inst=8'h00, irq_o=1.
- NMI edge: pulse nmi 0→1 while rdy=0 → nmi_pend set and nmi_o=1. Hold nmi=1 through sinst → nmi_o=0, with no re-trigger until nmi falls and rises again.
- Priority and wrap: rcyc+icyc together at cycle=5 → cycle=0. scyc at cycle=6 → cycle=0. scyc at cycle=7 → cycle=1. icyc at cycle=7 → cycle=0.
- Hang: HANG_LIMIT=16, rdy=1 with no strobes. Required: hang stays 0 after 15 cycles and is 1 after 16. With rdy=0 for 20 cycles, hang stays 0. An icyc mid-count restarts the count.
- Reset mid-operation: cycle=3, nmi_pend=1, inst=8'h6D, then clr=1 → cycle=0, inst=8'h00, rst_o=1, nmi_o=0, nmi_pend=0, hang=0.

Source files
------------

// File: rtl/cycle_seq.sv
//------------------------------------------------------------------------------
// cycle_seq
//
// Timing and sequencing controller for the 6502 core. Holds the instruction
// register and the 3-bit cycle counter consumed by the instruction decoder,
// latches reset and NMI requests, qualifies IRQ, injects the interrupt opcode
// at instruction boundaries and flags a hang when the decoder stops
// sequencing.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_clr    synchronous active-high reset
//   i_rdy    1 = advance, 0 = freeze sequencing (NMI edge capture continues)
//   i_din    data bus, opcode source on rcyc
//   i_irq    level interrupt request
//   i_nmi    non-maskable request, rising-edge sensitive
//   i_idis   status I flag, 1 masks irq
//   i_icyc   decoder strobe: cycle + 1
//   i_rcyc   decoder strobe: last cycle, cycle = 0 and load next opcode
//   i_scyc   decoder strobe: cycle + 2
//   i_sinst  decoder strobe: interrupt sequence accepted
//   o_inst   instruction register
//   o_cycle  cycle counter
//   o_rst    pending reset
//   o_nmi    pending NMI (masked by pending reset)
//   o_irq    qualified IRQ (combinational)
//   o_sync   first cycle of an instruction
//   o_hang   sticky hang flag
//------------------------------------------------------------------------------
module cycle_seq #(
   parameter logic [7:0] INT_OP     = 8'h00,
   parameter int         HANG_LIMIT = 16
) (
   input  logic       i_clk,
   input  logic       i_clr,
   input  logic       i_rdy,
   input  logic [7:0] i_din,
   input  logic       i_irq,
   input  logic       i_nmi,
   input  logic       i_idis,
   input  logic       i_icyc,
   input  logic       i_rcyc,
   input  logic       i_scyc,
   input  logic       i_sinst,
   output logic [7:0] o_inst,
   output logic [2:0] o_cycle,
   output logic       o_rst,
   output logic       o_nmi,
   output logic       o_irq,
   output logic       o_sync,
   output logic       o_hang
);

   localparam logic [7:0] LP_HANG_LIMIT = 8'(HANG_LIMIT);

   logic [2:0] r_cycle;
   logic [7:0] r_inst;
   logic       r_rst_pend;
   logic       r_nmi_pend;
   logic       r_nmi_q;
   logic       r_sync;
   logic       r_hang;
   logic [7:0] r_stall;

   logic       w_irq;
   logic       w_int_take;
   logic       w_nmi_edge;
   logic       w_any_strobe;
   logic [7:0] w_stall_nxt;

   // IRQ is never latched: it is only visible while no reset/NMI is pending.
   assign w_irq        = i_irq & ~i_idis & ~r_rst_pend & ~r_nmi_pend;
   assign w_int_take   = r_rst_pend | r_nmi_pend | w_irq;
   assign w_nmi_edge   = i_nmi & ~r_nmi_q;
   assign w_any_strobe = i_rcyc | i_scyc | i_icyc | i_sinst;

   // Next stall count: cleared by any decoder strobe, saturating at the limit.
   always_comb begin
      w_stall_nxt = r_stall;
      if (w_any_strobe) begin
         w_stall_nxt = 8'd0;
      end else if (r_stall >= LP_HANG_LIMIT) begin
         w_stall_nxt = LP_HANG_LIMIT;
      end else begin
         w_stall_nxt = r_stall + 8'd1;
      end
   end

   // Reset/NMI pending flags and the NMI edge detector (runs even when rdy=0).
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_rst_pend <= 1'b1;
         r_nmi_pend <= 1'b0;
         r_nmi_q    <= 1'b0;
      end else begin
         r_nmi_q <= i_nmi;
         if (i_rdy && i_sinst && r_rst_pend) begin
            r_rst_pend <= 1'b0;
         end
         // A fresh edge wins over a simultaneous retire of the NMI.
         if (w_nmi_edge) begin
            r_nmi_pend <= 1'b1;
         end else if (i_rdy && i_sinst && !r_rst_pend) begin
            r_nmi_pend <= 1'b0;
         end
      end
   end

   // Cycle counter, instruction register and sync; rcyc > scyc > icyc.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_cycle <= 3'd0;
         r_inst  <= INT_OP;
         r_sync  <= 1'b1;
      end else if (i_rdy) begin
         if (i_rcyc) begin
            r_cycle <= 3'd0;
            r_sync  <= 1'b1;
            r_inst  <= w_int_take ? INT_OP : i_din;
         end else if (i_scyc) begin
            r_cycle <= r_cycle + 3'd2;
            r_sync  <= 1'b0;
         end else if (i_icyc) begin
            r_cycle <= r_cycle + 3'd1;
            r_sync  <= 1'b0;
         end
      end
   end

   // Stall counter and sticky hang flag; both frozen while rdy=0.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_stall <= 8'd0;
         r_hang  <= 1'b0;
      end else if (i_rdy) begin
         r_stall <= w_stall_nxt;
         if (w_stall_nxt == LP_HANG_LIMIT) begin
            r_hang <= 1'b1;
         end
      end
   end

   assign o_inst  = r_inst;
   assign o_cycle = r_cycle;
   assign o_rst   = r_rst_pend;
   assign o_nmi   = r_nmi_pend & ~r_rst_pend;
   assign o_irq   = w_irq;
   assign o_sync  = r_sync;
   assign o_hang  = r_hang;

endmodule
